pp_accumulate: RTL and testbench

Sequential accumulator directly downstream of the partial-product aligner in the MAC subsystem. It takes a group of `NUM_PP` aligned 15-bit two's-complement partial products, one per handshake. Each product is already aligned to a common `max_exp`. The block sums the group in a single sign-extended register and presents the group sum, together with its exponent, to the normaliser through a valid/ready handshake.

---
 rtl/pp_accumulate_if.sv | 36 +++
 rtl/pp_accumulate.sv | 101 ++++++++++
 tb/tb_pp_accumulate.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pp_accumulate_if.sv
// Stream bundle between the partial-product aligner, the accumulator and the normaliser.
// The i_clear abort line exists only when PP_ACC_CLEAR_EN is defined.
interface pp_accumulate_if #(
  parameter int unsigned NUM_PP = 4,
  parameter int unsigned PP_W   = 15,
  parameter int unsigned EXP_W  = 6,
  parameter int unsigned SUM_W  = PP_W + $clog2(NUM_PP)
);
  logic             i_valid;
  logic             o_ready;
  logic [PP_W-1:0]  i_align_pp;
  logic [EXP_W-1:0] i_max_exp;
  logic             o_valid;
  logic             i_ready;
  logic [SUM_W-1:0] o_sum;
  logic [EXP_W-1:0] o_exp;
`ifdef PP_ACC_CLEAR_EN
  logic             i_clear;
`endif

  modport master (
`ifdef PP_ACC_CLEAR_EN
    output i_clear,
`endif
    output i_valid, i_align_pp, i_max_exp, i_ready,
    input  o_ready, o_valid, o_sum, o_exp
  );

  modport slave (
`ifdef PP_ACC_CLEAR_EN
    input  i_clear,
`endif
    input  i_valid, i_align_pp, i_max_exp, i_ready,
    output o_ready, o_valid, o_sum, o_exp
  );
endinterface

// File: rtl/pp_accumulate.sv
// Sums NUM_PP aligned partial products per group and hands the sum plus exponent downstream.
// Optional group abort input i_clear is enabled by defining PP_ACC_CLEAR_EN.
module pp_accumulate #(
  parameter int unsigned NUM_PP = 4,
  parameter int unsigned PP_W   = 15,
  parameter int unsigned EXP_W  = 6,
  parameter int unsigned SUM_W  = PP_W + $clog2(NUM_PP)
) (
  input logic           i_clk,
  input logic           i_rst,
  pp_accumulate_if.slave bus
);
  localparam int unsigned CNT_W = (NUM_PP > 1) ? $clog2(NUM_PP) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_PP - 1);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [SUM_W-1:0] acc;
  logic [EXP_W-1:0] exp_r;
  logic             valid_r;
  logic             ready_r;
  logic [SUM_W-1:0] pp_ext;
  logic             acc_fire;
  logic             out_fire;

  assign pp_ext   = SUM_W'($signed(bus.i_align_pp));
  assign acc_fire = bus.i_valid & ready_r;
  assign out_fire = valid_r & bus.i_ready;

  assign bus.o_ready = ready_r;
  assign bus.o_valid = valid_r;
  assign bus.o_sum   = acc;
  assign bus.o_exp   = exp_r;

  // Handshake flags are registered alongside the state so o_ready never depends on i_ready.
  // cnt wraps on the last beat; LAST is compared before the increment.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      exp_r   <= '0;
      valid_r <= 1'b0;
      ready_r <= 1'b1;
    end
`ifdef PP_ACC_CLEAR_EN
    else if (bus.i_clear) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      valid_r <= 1'b0;
      ready_r <= 1'b1;
    end
`endif
    else begin
      case (state)
        IDLE: begin
          if (acc_fire) begin
            acc   <= pp_ext;
            exp_r <= bus.i_max_exp;
            cnt   <= CNT_W'(1);
            if (NUM_PP == 1) begin
              state   <= HOLD;
              valid_r <= 1'b1;
              ready_r <= 1'b0;
            end else begin
              state <= ACC;
            end
          end
        end
        ACC: begin
          if (acc_fire) begin
            acc <= acc + pp_ext;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
              state   <= HOLD;
              valid_r <= 1'b1;
              ready_r <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (out_fire) begin
            state   <= IDLE;
            cnt     <= '0;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          valid_r <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pp_accumulate.sv
// Directed self-checking bench for pp_accumulate (NUM_PP=4, PP_W=15, EXP_W=6, SUM_W=17).
// Define PP_ACC_CLEAR_EN to also exercise the group abort input.
module tb_pp_accumulate;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  pp_accumulate_if #(.NUM_PP(4), .PP_W(15), .EXP_W(6), .SUM_W(17)) bus ();

  pp_accumulate #(.NUM_PP(4), .PP_W(15), .EXP_W(6), .SUM_W(17)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [14:0] pp, input logic [5:0] e);
    bus.i_valid    = 1'b1;
    bus.i_align_pp = pp;
    bus.i_max_exp  = e;
    step();
    bus.i_valid    = 1'b0;
    bus.i_align_pp = 15'h5555;
    bus.i_max_exp  = 6'd63;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.o_valid); end
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.o_ready); end
    checks++; if (bus.o_sum !== 17'h00000) begin errors++; $display("FAIL reset_sum got=%h exp=00000", bus.o_sum); end
    checks++; if (bus.o_exp !== 6'd0) begin errors++; $display("FAIL reset_exp got=%0d exp=0", bus.o_exp); end
  endtask

  task automatic test_max_sum();
    bus.i_ready = 1'b1;
    for (int i = 0; i < 3; i++) beat(15'h3800, 6'd20);
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL max_early_valid got=%b exp=0", bus.o_valid); end
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL max_acc_ready got=%b exp=1", bus.o_ready); end
    beat(15'h3800, 6'd20);
    checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL max_valid got=%b exp=1", bus.o_valid); end
    checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL max_hold_ready got=%b exp=0", bus.o_ready); end
    checks++; if (bus.o_sum !== 17'h0E000) begin errors++; $display("FAIL max_sum got=%h exp=0e000", bus.o_sum); end
    checks++; if (bus.o_exp !== 6'd20) begin errors++; $display("FAIL max_exp got=%0d exp=20", bus.o_exp); end
    step();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL max_idle_valid got=%b exp=0", bus.o_valid); end
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL max_idle_ready got=%b exp=1", bus.o_ready); end
  endtask

  task automatic test_mixed_signs();
    bus.i_ready = 1'b1;
    beat(15'h3800, 6'd5);
    beat(15'h7800, 6'd5);
    beat(15'h4800, 6'd5);
    beat(15'h0001, 6'd5);
    checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL mixed_valid got=%b exp=1", bus.o_valid); end
    checks++; if (bus.o_sum !== 17'h1F801) begin errors++; $display("FAIL mixed_sum got=%h exp=1f801", bus.o_sum); end
    checks++; if (bus.o_exp !== 6'd5) begin errors++; $display("FAIL mixed_exp got=%0d exp=5", bus.o_exp); end
    step();
  endtask

  task automatic test_backpressure();
    bus.i_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(15'h0100, 6'd3);
    for (int i = 0; i < 5; i++) begin
      bus.i_valid    = 1'b1;
      bus.i_align_pp = 15'h1234;
      bus.i_max_exp  = 6'd9;
      checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, bus.o_valid); end
      checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, bus.o_ready); end
      checks++; if (bus.o_sum !== 17'h00400) begin errors++; $display("FAIL bp_sum[%0d] got=%h exp=00400", i, bus.o_sum); end
      checks++; if (bus.o_exp !== 6'd3) begin errors++; $display("FAIL bp_exp[%0d] got=%0d exp=3", i, bus.o_exp); end
      step();
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    checks++; if (bus.o_sum !== 17'h00400) begin errors++; $display("FAIL bp_sum_final got=%h exp=00400", bus.o_sum); end
    step();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%b exp=0", bus.o_valid); end
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", bus.o_ready); end
  endtask

  task automatic test_gaps();
    logic        vpat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [14:0] dpat [7] = '{15'd10, 15'd100, 15'd200, 15'd20, 15'd30, 15'd300, 15'd40};
    bus.i_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.i_valid    = vpat[i];
      bus.i_align_pp = dpat[i];
      bus.i_max_exp  = (i == 0) ? 6'd7 : 6'd9;
      if (i == 6) begin
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL gap_early_valid got=%b exp=0", bus.o_valid); end
      end
      step();
    end
    bus.i_valid = 1'b0;
    checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL gap_valid got=%b exp=1", bus.o_valid); end
    checks++; if (bus.o_sum !== 17'd100) begin errors++; $display("FAIL gap_sum got=%0d exp=100", bus.o_sum); end
    checks++; if (bus.o_exp !== 6'd7) begin errors++; $display("FAIL gap_exp got=%0d exp=7", bus.o_exp); end
    step();
  endtask

  task automatic test_reset_mid();
    bus.i_ready = 1'b1;
    beat(15'h0800, 6'd11);
    beat(15'h0800, 6'd11);
    rst = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_align_pp = 15'h0800;
    step();
    rst = 1'b0;
    bus.i_valid = 1'b0;
    checks++; if (bus.o_sum !== 17'h00000) begin errors++; $display("FAIL rmid_sum got=%h exp=00000", bus.o_sum); end
    checks++; if (bus.o_exp !== 6'd0) begin errors++; $display("FAIL rmid_exp got=%0d exp=0", bus.o_exp); end
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got=%b exp=1", bus.o_ready); end
    for (int i = 0; i < 4; i++) beat(15'h0800, 6'd2);
    checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL rmid_valid got=%b exp=1", bus.o_valid); end
    checks++; if (bus.o_sum !== 17'd8192) begin errors++; $display("FAIL rmid_next_sum got=%0d exp=8192", bus.o_sum); end
    checks++; if (bus.o_exp !== 6'd2) begin errors++; $display("FAIL rmid_next_exp got=%0d exp=2", bus.o_exp); end
    step();
    bus.i_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(15'h0010, 6'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.i_ready = 1'b1;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL rhold_valid got=%b exp=0", bus.o_valid); end
    checks++; if (bus.o_sum !== 17'h00000) begin errors++; $display("FAIL rhold_sum got=%h exp=00000", bus.o_sum); end
  endtask

`ifdef PP_ACC_CLEAR_EN
  task automatic test_clear();
    bus.i_ready = 1'b1;
    beat(15'h0100, 6'd4);
    beat(15'h0100, 6'd4);
    bus.i_clear = 1'b1;
    beat(15'h0100, 6'd4);
    bus.i_clear = 1'b0;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL clr_valid got=%b exp=0", bus.o_valid); end
    checks++; if (bus.o_sum !== 17'h00000) begin errors++; $display("FAIL clr_sum got=%h exp=00000", bus.o_sum); end
    checks++; if (bus.o_exp !== 6'd4) begin errors++; $display("FAIL clr_exp got=%0d exp=4", bus.o_exp); end
    for (int i = 0; i < 4; i++) beat(15'h0001, 6'd13);
    checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL clr_next_valid got=%b exp=1", bus.o_valid); end
    checks++; if (bus.o_sum !== 17'd4) begin errors++; $display("FAIL clr_next_sum got=%0d exp=4", bus.o_sum); end
    checks++; if (bus.o_exp !== 6'd13) begin errors++; $display("FAIL clr_next_exp got=%0d exp=13", bus.o_exp); end
    bus.i_ready = 1'b0;
    step();
    bus.i_clear = 1'b1;
    step();
    bus.i_clear = 1'b0;
    bus.i_ready = 1'b1;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL clr_hold_valid got=%b exp=0", bus.o_valid); end
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL clr_hold_ready got=%b exp=1", bus.o_ready); end
  endtask
`endif

  initial begin
    errors         = 0;
    checks         = 0;
    rst            = 1'b0;
    bus.i_valid    = 1'b0;
    bus.i_align_pp = '0;
    bus.i_max_exp  = '0;
    bus.i_ready    = 1'b1;
`ifdef PP_ACC_CLEAR_EN
    bus.i_clear    = 1'b0;
`endif
    test_reset();
    test_max_sum();
    test_mixed_signs();
    test_backpressure();
    test_gaps();
    test_reset_mid();
`ifdef PP_ACC_CLEAR_EN
    test_clear();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
